// File: rtl/bel_avl_burst_ram.sv
// Avalon-MM slave RAM for bel_fft benches: byte-enabled single-beat writes, wrapping read
// bursts that hold waitrequest while they fetch, and a configurable read-latency pipeline.
module bel_avl_burst_ram #(
  parameter int DWIDTH     = 32,
  parameter int ADR_WIDTH  = 6,
  parameter int SIZE       = 64,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 8,
  parameter int BCNT_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADR_WIDTH-1:0]  address,
  input  logic [DWIDTH/8-1:0]   byteenable,
  input  logic                  read,
  input  logic                  write,
  input  logic [DWIDTH-1:0]     writedata,
  input  logic [BCNT_WIDTH-1:0] burstcount,
  output logic                  waitrequest,
  output logic [DWIDTH-1:0]     readdata,
  output logic                  readdatavalid
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || SIZE != 2**ADR_WIDTH || DWIDTH % 8 != 0) begin : g_param_err
    $error("bel_avl_burst_ram: illegal parameters (RD_LATENCY=%0d SIZE=%0d ADR_WIDTH=%0d DWIDTH=%0d)",
           RD_LATENCY, SIZE, ADR_WIDTH, DWIDTH);
  end

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e                state_q, state_d;
  logic [BCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0]  baddr_q, baddr_d;

  logic [DWIDTH-1:0]     mem_q [SIZE];
  logic [RD_LATENCY-1:0] vld_q;
  logic [DWIDTH-1:0]     dat_q [RD_LATENCY];

  logic                  rd_accept;
  logic                  wr_accept;
  logic                  fetch_en;
  logic [ADR_WIDTH-1:0]  fetch_addr;
  logic [BCNT_WIDTH-1:0] beats;

  // A simultaneous read and write is treated as a write; the read never enters the pipeline.
  assign wr_accept = write & ~waitrequest;
  assign rd_accept = read & ~write & ~waitrequest;

  always_comb begin
    beats = burstcount;
    if (burstcount == '0) begin
      beats = BCNT_WIDTH'(1);
    end else if (burstcount > BCNT_WIDTH'(MAX_BURST)) begin
      beats = BCNT_WIDTH'(MAX_BURST);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    baddr_d     = baddr_q;
    waitrequest = 1'b0;
    fetch_en    = rd_accept;
    fetch_addr  = address;
    unique case (state_q)
      S_IDLE: begin
        if (rd_accept && beats > BCNT_WIDTH'(1)) begin
          state_d = S_BURST;
          cnt_d   = beats - 1'b1;
          baddr_d = address + 1'b1;
        end
      end
      S_BURST: begin
        waitrequest = 1'b1;
        fetch_en    = 1'b1;
        fetch_addr  = baddr_q;
        cnt_d       = cnt_q - 1'b1;
        baddr_d     = baddr_q + 1'b1;
        if (cnt_q == BCNT_WIDTH'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      baddr_q <= baddr_d;
    end
  end

  // NOTE: the array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < DWIDTH / 8; b++) begin
        if (byteenable[b]) begin
          mem_q[address][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 is the array fetch; the remaining RD_LATENCY-1 stages only delay it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= fetch_en;
      if (fetch_en) begin
        dat_q[0] <= mem_q[fetch_addr];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign readdata      = dat_q[RD_LATENCY-1];
  assign readdatavalid = vld_q[RD_LATENCY-1];

endmodule

// File: tb/tb_bel_avl_burst_ram.sv
// Self-checking bench for bel_avl_burst_ram: directed edge cases plus a random command mix,
// scored against a word-array model that predicts every beat's data and arrival cycle.
module tb_bel_avl_burst_ram;

  localparam int DW   = 32;
  localparam int AW   = 6;
  localparam int SZ   = 64;
  localparam int LAT  = 3;
  localparam int MAXB = 8;
  localparam int BW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] address = '0;
  logic [3:0]    byteenable = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic [BW-1:0] burstcount = '0;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  always #5 clk = ~clk;

  bel_avl_burst_ram #(
    .DWIDTH(DW), .ADR_WIDTH(AW), .SIZE(SZ), .RD_LATENCY(LAT), .MAX_BURST(MAXB), .BCNT_WIDTH(BW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .address(address), .byteenable(byteenable), .read(read),
    .write(write), .writedata(writedata), .burstcount(burstcount), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] mem_m [SZ];
  logic [DW-1:0] got_d [$];
  logic [DW-1:0] exp_d [$];
  int            got_c [$];
  int            exp_c [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      got_d.push_back(readdata);
      got_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input logic [BW-1:0] bc);
    if (bc == 0) return 1;
    if (int'(bc) > MAXB) return MAXB;
    return int'(bc);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [3:0] be);
    logic [DW-1:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic idle();
    read  = 1'b0;
    write = 1'b0;
  endtask

  // Presents one command for a single clock edge; c is the cycle it was presented in.
  task automatic drive(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [3:0] be,
                       input logic [DW-1:0] d, input logic [BW-1:0] bc, output int c);
    read = rd; write = wr; address = a; byteenable = be; writedata = d; burstcount = bc;
    c = cyc;
    @(posedge clk); #1;
  endtask

  task automatic expect_read(input int c, input logic [AW-1:0] a, input logic [BW-1:0] bc);
    for (int k = 0; k < clamp(bc); k++) begin
      exp_d.push_back(mem_m[(int'(a) + k) % SZ]);
      exp_c.push_back(c + LAT + k);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    idle();
    while (waitrequest !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_bound", {63'd0, waitrequest}, 64'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    int c;
    wait_ready();
    drive(1'b0, 1'b1, a, be, d, '0, c);
    mem_m[a] = merge(mem_m[a], d, be);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [BW-1:0] bc);
    int c;
    wait_ready();
    drive(1'b1, 1'b0, a, '0, '0, bc, c);
    expect_read(c, a, bc);
  endtask

  task automatic compare(input string tag);
    int n;
    idle();
    repeat (LAT + MAXB + 3) begin @(posedge clk); #1; end
    check({tag, "_beats"}, 64'(got_d.size()), 64'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, 64'(got_d[i]), 64'(exp_d[i]));
      check({tag, "_cycle"}, 64'(got_c[i]), 64'(exp_c[i]));
    end
    got_d.delete(); got_c.delete(); exp_d.delete(); exp_c.delete();
  endtask

  initial begin
    int c;
    int keep;
    logic [31:0] r;

    #1 rst_n = 1'b0;
    #2;
    check("rst_waitrequest", {63'd0, waitrequest}, 64'd0);
    check("rst_rdvalid", {63'd0, readdatavalid}, 64'd0);
    check("rst_readdata", 64'(readdata), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < SZ; i++) do_write(AW'(i), 4'hF, $urandom());

    do_write(6'd5, 4'hF, 32'h1122_3344);
    do_write(6'd5, 4'b0101, 32'hAABB_CCDD);
    do_read(6'd5, 4'd1);
    check("be_model", 64'(mem_m[5]), 64'h11BB_33DD);
    compare("byteenable");

    wait_ready();
    drive(1'b1, 1'b0, 6'd62, '0, '0, 4'd4, c);
    expect_read(c, 6'd62, 4'd4);
    idle();
    for (int i = 1; i <= 4; i++) begin
      check("burst_waitrequest", {63'd0, waitrequest}, (i < 4) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    compare("burst_wrap");

    wait_ready();
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b0, AW'(a), '0, '0, 4'd1, c);
      expect_read(c, AW'(a), 4'd1);
    end
    compare("pipelined");

    do_write(6'd20, 4'hF, 32'hCAFE_F00D);
    do_read(6'd20, 4'd1);
    compare("raw");

    wait_ready();
    drive(1'b1, 1'b1, 6'd9, 4'hF, 32'h0BAD_BEEF, 4'd1, c);
    mem_m[9] = 32'h0BAD_BEEF;
    compare("rd_wr_same");
    do_read(6'd9, 4'd1);
    compare("rd_wr_landed");

    do_read(6'd30, 4'd0);
    compare("bc_zero");
    do_read(6'd60, 4'd15);
    compare("bc_clamp");

    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a = AW'($urandom_range(0, SZ - 1));
      case ($urandom_range(0, 3))
        0: do_write(a, 4'($urandom_range(0, 15)), $urandom());
        1: do_read(a, 4'd1);
        2: do_read(a, 4'($urandom_range(0, 15)));
        default: begin
          r = $urandom();
          wait_ready();
          drive(1'b1, 1'b1, a, 4'hF, r, 4'($urandom_range(0, 15)), c);
          mem_m[a] = r;
        end
      endcase
    end
    compare("random");

    wait_ready();
    drive(1'b1, 1'b0, 6'd40, '0, '0, 4'd8, c);
    idle();
    keep = exp_d.size() + 3;
    expect_read(c, 6'd40, 4'd8);
    while (exp_d.size() > keep) begin
      void'(exp_d.pop_back());
      void'(exp_c.pop_back());
    end
    while (cyc < c + 6) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("async_waitrequest", {63'd0, waitrequest}, 64'd0);
    check("async_rdvalid", {63'd0, readdatavalid}, 64'd0);
    check("async_readdata", 64'(readdata), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    compare("reset_burst");

    for (int a = 40; a < 44; a++) do_read(AW'(a), 4'd1);
    compare("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
